writedest_fifo: RTL and testbench



---
 rtl/writedest_fifo_if.sv | 25 ++
 rtl/writedest_fifo.sv | 134 +++++++++++++
 tb/tb_writedest_fifo.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/writedest_fifo_if.sv
// Pixel stream and WISHBONE write-master signals for writedest_fifo.
// The design connects through "master"; the pixel source and bus slave side through "slave".
interface writedest_fifo_if;
  logic [29:0] d_addr;
  logic [23:0] d_data;
  logic        d_ready;
  logic        d_next;
  logic [31:0] mwb_adr_o;
  logic        mwb_cyc_o;
  logic        mwb_stb_o;
  logic        mwb_we_o;
  logic        mwb_ack_i;
  logic [31:0] mwb_dat_o;
  logic [3:0]  mwb_sel_o;

  modport master (
    input  d_addr, d_data, d_ready, mwb_ack_i,
    output d_next, mwb_adr_o, mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_dat_o, mwb_sel_o
  );

  modport slave (
    output d_addr, d_data, d_ready, mwb_ack_i,
    input  d_next, mwb_adr_o, mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_dat_o, mwb_sel_o
  );
endinterface

// File: rtl/writedest_fifo.sv
// Write-back stage: queues destination pixels and issues back-to-back WISHBONE
// single writes in XRGB8888 or big-endian RGB565 framebuffer format.
module writedest_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int FORMAT          = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  writedest_fifo_if.master         bus,
  output logic [FIFO_DEPTH_LOG2:0] fill_o,
  output logic                     idle_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                     state_reg, state_next;
  logic [53:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   count_reg;
  logic                       push, pop, fifo_empty, fifo_full;
  logic [53:0]                head;
  logic [29:0]                head_addr;
  logic [23:0]                head_data;
  logic [31:0]                load_adr, load_dat;
  logic [3:0]                 load_sel;
  logic [31:0]                adr_reg, dat_reg;
  logic [3:0]                 sel_reg;

  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);
  // Acceptance depends only on the registered count, so a same-cycle pop never frees a slot.
  assign push       = bus.d_ready & ~fifo_full;

  assign head      = mem[rd_ptr_reg];
  assign head_addr = head[53:24];
  assign head_data = head[23:0];

  generate
    if (FORMAT == 1) begin : g_rgb565
      logic [15:0] pix;
      logic        unused_lsbs;
      assign pix         = {head_data[23:19], head_data[15:10], head_data[7:3]};
      assign load_adr    = {1'b0, head_addr[29:1], 2'b00};
      assign load_dat    = {pix, pix};
      // Even pixel index is the upper halfword of the big-endian word.
      assign load_sel    = head_addr[0] ? 4'b0011 : 4'b1100;
      assign unused_lsbs = ^{head_data[18:16], head_data[9:8], head_data[2:0]};
    end else begin : g_xrgb8888
      assign load_adr = {head_addr, 2'b00};
      assign load_dat = {8'h00, head_data};
      assign load_sel = 4'b0111;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.d_addr, bus.d_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Ack is only looked at in BUSY, so a stray ack while idle has no effect.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.mwb_ack_i) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_reg <= '0;
      dat_reg <= '0;
      sel_reg <= '0;
    end else if (pop) begin
      adr_reg <= load_adr;
      dat_reg <= load_dat;
      sel_reg <= load_sel;
    end
  end

  assign bus.d_next    = ~fifo_full;
  assign bus.mwb_stb_o = (state_reg == ST_BUSY);
  assign bus.mwb_cyc_o = (state_reg == ST_BUSY);
  assign bus.mwb_we_o  = 1'b1;
  assign bus.mwb_adr_o = adr_reg;
  assign bus.mwb_dat_o = dat_reg;
  assign bus.mwb_sel_o = sel_reg;
  assign fill_o        = count_reg;
  assign idle_o        = fifo_empty & (state_reg != ST_BUSY);

endmodule

// File: tb/tb_writedest_fifo.sv
// Directed bench: XRGB8888 unit with a 4-entry FIFO and RGB565 unit with an 8-entry FIFO,
// exercising latency, formatting, full/backpressure, back-to-back writes and async reset.
module tb_writedest_fifo;
  logic       clk;
  logic       rst_n;
  logic [2:0] fill_a;
  logic [3:0] fill_b;
  logic       idle_a, idle_b;
  int         n_checks;
  int         n_errors;

  writedest_fifo_if ifa ();
  writedest_fifo_if ifb ();

  writedest_fifo #(.FIFO_DEPTH_LOG2(2), .FORMAT(0)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (ifa.master),
    .fill_o (fill_a),
    .idle_o (idle_a)
  );

  writedest_fifo #(.FIFO_DEPTH_LOG2(3), .FORMAT(1)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (ifb.master),
    .fill_o (fill_b),
    .idle_o (idle_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      $display("check %s: observed %0h", tag, obs);
    end else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ifa.d_addr = '0; ifa.d_data = '0; ifa.d_ready = 1'b0; ifa.mwb_ack_i = 1'b0;
    ifb.d_addr = '0; ifb.d_data = '0; ifb.d_ready = 1'b0; ifb.mwb_ack_i = 1'b0;

    // Reset state
    #1;
    chk("rst_stb",    ifa.mwb_stb_o, 1'b0);
    chk("rst_cyc",    ifa.mwb_cyc_o, 1'b0);
    chk("rst_we",     ifa.mwb_we_o, 1'b1);
    chk("rst_adr",    ifa.mwb_adr_o, 32'h0);
    chk("rst_dat",    ifa.mwb_dat_o, 32'h0);
    chk("rst_sel",    ifa.mwb_sel_o, 4'h0);
    chk("rst_fill",   fill_a, 3'd0);
    chk("rst_dnext",  ifa.d_next, 1'b1);
    chk("rst_idle",   idle_a, 1'b1);
    chk("rst_idle_b", idle_b, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // FORMAT 0 single write, latency and ack
    ifa.d_ready = 1'b1; ifa.d_addr = 30'h10; ifa.d_data = 24'hABCDEF;
    tick();
    ifa.d_ready = 1'b0;
    chk("f0_stb_at_push", ifa.mwb_stb_o, 1'b0);
    chk("f0_fill_at_push", fill_a, 3'd1);
    tick();
    chk("f0_stb", ifa.mwb_stb_o, 1'b1);
    chk("f0_cyc", ifa.mwb_cyc_o, 1'b1);
    chk("f0_adr", ifa.mwb_adr_o, 32'h40);
    chk("f0_dat", ifa.mwb_dat_o, 32'h00ABCDEF);
    chk("f0_sel", ifa.mwb_sel_o, 4'b0111);
    chk("f0_idle_busy", idle_a, 1'b0);
    ifa.mwb_ack_i = 1'b1;
    tick();
    ifa.mwb_ack_i = 1'b0;
    chk("f0_stb_after_ack", ifa.mwb_stb_o, 1'b0);
    chk("f0_idle_after_ack", idle_a, 1'b1);

    // FORMAT 1: odd then even pixel index
    ifb.d_ready = 1'b1; ifb.d_addr = 30'd5; ifb.d_data = 24'hFF0000;
    tick();
    ifb.d_addr = 30'd6;
    tick();
    ifb.d_ready = 1'b0;
    chk("f1_w0_stb", ifb.mwb_stb_o, 1'b1);
    chk("f1_w0_adr", ifb.mwb_adr_o, 32'h8);
    chk("f1_w0_sel", ifb.mwb_sel_o, 4'b0011);
    chk("f1_w0_dat", ifb.mwb_dat_o, 32'hF800F800);
    chk("f1_w0_fill", fill_b, 4'd1);
    ifb.mwb_ack_i = 1'b1;
    tick();
    chk("f1_w1_stb", ifb.mwb_stb_o, 1'b1);
    chk("f1_w1_adr", ifb.mwb_adr_o, 32'hC);
    chk("f1_w1_sel", ifb.mwb_sel_o, 4'b1100);
    chk("f1_w1_dat", ifb.mwb_dat_o, 32'hF800F800);
    tick();
    ifb.mwb_ack_i = 1'b0;
    chk("f1_stb_end", ifb.mwb_stb_o, 1'b0);
    chk("f1_idle_end", idle_b, 1'b1);

    // Full FIFO with ack held low: 1 on the bus + 4 queued, further pushes refused
    ifa.d_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ifa.d_addr = 30'h100 + 30'(k);
      ifa.d_data = 24'h000100 + 24'(k);
      tick();
    end
    ifa.d_ready = 1'b0;
    chk("full_fill", fill_a, 3'd4);
    chk("full_dnext", ifa.d_next, 1'b0);
    chk("full_stb", ifa.mwb_stb_o, 1'b1);
    chk("full_adr0", ifa.mwb_adr_o, 32'h400);
    chk("full_dat0", ifa.mwb_dat_o, 32'h00000100);
    ifa.mwb_ack_i = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("drain_stb%0d", k), ifa.mwb_stb_o, 1'b1);
      chk($sformatf("drain_adr%0d", k), ifa.mwb_adr_o, 64'h400 + 64'(4 * k));
      chk($sformatf("drain_dat%0d", k), ifa.mwb_dat_o, 64'h100 + 64'(k));
      chk($sformatf("drain_fill%0d", k), fill_a, 64'(4 - k));
    end
    tick();
    chk("drain_stb_end", ifa.mwb_stb_o, 1'b0);
    chk("drain_dnext_end", ifa.d_next, 1'b1);

    // Ack held high, 8 continuous pushes -> 8 back-to-back writes
    ifa.d_ready = 1'b1; ifa.d_addr = 30'h200; ifa.d_data = 24'h0;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k < 7) ifa.d_addr = 30'h200 + 30'(k + 1);
      else       ifa.d_ready = 1'b0;
      tick();
      chk($sformatf("b2b_stb%0d", k), ifa.mwb_stb_o, 1'b1);
      chk($sformatf("b2b_adr%0d", k), ifa.mwb_adr_o, 64'h800 + 64'(4 * k));
    end
    tick();
    ifa.mwb_ack_i = 1'b0;
    chk("b2b_stb_end", ifa.mwb_stb_o, 1'b0);

    // Push and ack in the same edge with fill_o = 2
    ifb.d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ifb.d_addr = 30'h20 + 30'(2 * k);
      ifb.d_data = 24'h00FC00;
      tick();
    end
    chk("sim_fill_pre", fill_b, 4'd2);
    chk("sim_adr_pre", ifb.mwb_adr_o, 32'h40);
    ifb.d_addr = 30'h26;
    ifb.mwb_ack_i = 1'b1;
    tick();
    ifb.d_ready = 1'b0;
    chk("sim_fill", fill_b, 4'd2);
    chk("sim_adr", ifb.mwb_adr_o, 32'h44);
    chk("sim_stb", ifb.mwb_stb_o, 1'b1);
    chk("sim_dat", ifb.mwb_dat_o, 32'h07E007E0);
    chk("sim_sel", ifb.mwb_sel_o, 4'b1100);
    tick();
    chk("sim_adr2", ifb.mwb_adr_o, 32'h48);
    tick();
    chk("sim_adr3", ifb.mwb_adr_o, 32'h4C);
    tick();
    ifb.mwb_ack_i = 1'b0;
    chk("sim_stb_end", ifb.mwb_stb_o, 1'b0);

    // Asynchronous reset while a write is in flight and 3 entries are queued
    ifa.d_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifa.d_addr = 30'h300 + 30'(k);
      tick();
    end
    ifa.d_ready = 1'b0;
    chk("ar_fill_pre", fill_a, 3'd3);
    chk("ar_stb_pre", ifa.mwb_stb_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_stb", ifa.mwb_stb_o, 1'b0);
    chk("ar_fill", fill_a, 3'd0);
    chk("ar_idle", idle_a, 1'b1);
    chk("ar_dnext", ifa.d_next, 1'b1);
    tick();
    rst_n = 1'b1;
    ifa.mwb_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ar_quiet_stb%0d", k), ifa.mwb_stb_o, 1'b0);
    end
    ifa.mwb_ack_i = 1'b0;

    // Stray ack while idle, then a fresh push still works after reset
    ifa.d_ready = 1'b1; ifa.d_addr = 30'h3FF; ifa.d_data = 24'h123456;
    tick();
    ifa.d_ready = 1'b0;
    tick();
    chk("post_stb", ifa.mwb_stb_o, 1'b1);
    chk("post_adr", ifa.mwb_adr_o, 32'hFFC);
    chk("post_dat", ifa.mwb_dat_o, 32'h00123456);
    ifa.mwb_ack_i = 1'b1;
    tick();
    ifa.mwb_ack_i = 1'b0;
    chk("post_idle", idle_a, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
